// File: rtl/blk_name_csr_pkg.sv
// -----------------------------------------------------------------------------
// blk_name_csr_pkg
//   Shared constants for the blk_name CSR block: register word addresses,
//   field bit positions, decode-error read pattern, counter ceiling, the
//   CSR handshake state type and a byte-enable expansion helper.
// -----------------------------------------------------------------------------
package blk_name_csr_pkg;

    // Register word addresses; the register file compares only the low
    // NP_AWIDTH bits of these.
    localparam logic [31:0] ADDR_REG_X = 32'h0000_0020;
    localparam logic [31:0] ADDR_REG_Y = 32'h0000_0021;
    localparam logic [31:0] ADDR_REG_Z = 32'h0000_0022;

    // REG_X fields. Field C is an alias of field B (same storage bits).
    localparam int REG_X_FIELD_A_LSB = 0;
    localparam int REG_X_FIELD_A_MSB = 7;
    localparam int REG_X_FIELD_B_LSB = 8;
    localparam int REG_X_FIELD_B_MSB = 15;
    localparam int REG_X_FIELD_C_LSB = 8;
    localparam int REG_X_FIELD_C_MSB = 15;

    // REG_Y sticky event bits occupy [NUM_EVT-1:0]; at most 16 events.
    localparam int REG_Y_EVT_LSB     = 0;
    localparam int REG_Y_EVT_MSB_MAX = 15;
    localparam int NUM_EVT_DEFAULT   = 8;

    // REG_Z full-width saturating event counter.
    localparam int          REG_Z_CNT_LSB = 0;
    localparam int          REG_Z_CNT_MSB = 31;
    localparam logic [31:0] REG_Z_CNT_MAX = 32'hFFFF_FFFF;

    // Read data returned for an unmapped read.
    localparam logic [31:0] DECODE_ERR_RDATA = 32'hDEADBEEF;

    typedef enum logic {CSR_IDLE, CSR_RESP} csr_state_t;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/blk_name_csr_if.sv
// -----------------------------------------------------------------------------
// blk_name_csr_if
//   CPU request/response bus of the blk_name CSR block.
//   Request : cpu_req_valid/ready, cpu_req_write, cpu_req_addr,
//             cpu_req_wdata, cpu_req_be
//   Response: cpu_resp_valid/ready, cpu_resp_rdata, cpu_resp_err
//   master = CPU side, slave = register file side.
// -----------------------------------------------------------------------------
interface blk_name_csr_if #(
    parameter int NP_AWIDTH = 16,
    parameter int NP_DWIDTH = 32
);
    logic                   cpu_req_valid;
    logic                   cpu_req_ready;
    logic                   cpu_req_write;
    logic [NP_AWIDTH-1:0]   cpu_req_addr;
    logic [NP_DWIDTH-1:0]   cpu_req_wdata;
    logic [NP_DWIDTH/8-1:0] cpu_req_be;
    logic                   cpu_resp_valid;
    logic                   cpu_resp_ready;
    logic [NP_DWIDTH-1:0]   cpu_resp_rdata;
    logic                   cpu_resp_err;

    modport master (
        output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
               cpu_req_be, cpu_resp_ready,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err
    );

    modport slave (
        input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
               cpu_req_be, cpu_resp_ready,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err
    );
endinterface

// File: rtl/blk_name_csr_evt_cnt.sv
// -----------------------------------------------------------------------------
// blk_name_csr_evt_cnt
//   32-bit saturating event counter with clear-on-read.
//   np_clk, np_rst : clock, synchronous active-high reset
//   inc            : count one event this cycle
//   clr            : counter is being read this cycle
//   count          : current value (the value a same-cycle read returns)
//   A read coinciding with an event leaves the counter at 1, so that event
//   is not lost.
// -----------------------------------------------------------------------------
module blk_name_csr_evt_cnt
    import blk_name_csr_pkg::*;
(
    input  logic        np_clk,
    input  logic        np_rst,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);
    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge np_clk) begin
        if (np_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= 32'(inc);
        end else if (inc && count != REG_Z_CNT_MAX) begin
            count <= count + 32'd1;
        end
    end
endmodule

// File: rtl/blk_name_csr_regs.sv
// -----------------------------------------------------------------------------
// blk_name_csr_regs
//   CSR register file for blk_name. One request at a time on a valid/ready
//   bus; response is registered and valid the cycle after acceptance.
//     REG_X 0x0020 RW  : [15:0] byte-enable gated, [31:16] read 0
//     REG_Y 0x0021 W1C : sticky hw_evt bits, event set wins over clear
//     REG_Z 0x0022 RO  : saturating count of cycles with any event,
//                        cleared on read
//   Ports:
//     np_clk, np_rst  : clock, synchronous active-high reset
//     cpu             : CSR bus (slave side)
//     hw_evt          : single-cycle event pulses
//     reg_x_field_a/b : REG_X[7:0] / REG_X[15:8]
//     evt_irq         : registered OR of the REG_Y sticky bits
// -----------------------------------------------------------------------------
module blk_name_csr_regs
    import blk_name_csr_pkg::*;
#(
    parameter int NP_AWIDTH = 16,
    parameter int NP_DWIDTH = 32,
    parameter int NUM_EVT   = NUM_EVT_DEFAULT
) (
    input  logic               np_clk,
    input  logic               np_rst,
    blk_name_csr_if.slave      cpu,
    input  logic [NUM_EVT-1:0] hw_evt,
    output logic [7:0]         reg_x_field_a,
    output logic [7:0]         reg_x_field_b,
    output logic               evt_irq
);
    csr_state_t         state_q, state_d;
    logic               accept;
    logic               req_ready, resp_valid;
    logic               sel_x, sel_y, sel_z;
    logic [31:0]        wmask;
    logic               wr_x, wr_y, rd_z;
    logic [15:0]        x_q;
    logic [NUM_EVT-1:0] y_q, y_clr, y_next;
    logic [31:0]        z_cnt;
    logic [31:0]        rdata_d, rdata_q;
    logic               err_d, err_q;

    // Handshake FSM.
    always_ff @(posedge np_clk) begin
        if (np_rst) state_q <= CSR_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            CSR_IDLE: begin
                req_ready = 1'b1;
                if (cpu.cpu_req_valid) begin
                    accept  = 1'b1;
                    state_d = CSR_RESP;
                end
            end
            CSR_RESP: begin
                resp_valid = 1'b1;
                if (cpu.cpu_resp_ready) state_d = CSR_IDLE;
            end
            default: state_d = CSR_IDLE;
        endcase
    end

    // Address decode and access strobes.
    always_comb begin
        sel_x = (cpu.cpu_req_addr == ADDR_REG_X[NP_AWIDTH-1:0]);
        sel_y = (cpu.cpu_req_addr == ADDR_REG_Y[NP_AWIDTH-1:0]);
        sel_z = (cpu.cpu_req_addr == ADDR_REG_Z[NP_AWIDTH-1:0]);
        wmask = be_to_mask(cpu.cpu_req_be);
        wr_x  = accept &  cpu.cpu_req_write & sel_x;
        wr_y  = accept &  cpu.cpu_req_write & sel_y;
        rd_z  = accept & ~cpu.cpu_req_write & sel_z;
        y_clr = wr_y ? (cpu.cpu_req_wdata[NUM_EVT-1:0] & wmask[NUM_EVT-1:0])
                     : '0;
        // Clear first, then set: an event in the same cycle wins.
        y_next = (y_q & ~y_clr) | hw_evt;
    end

    // REG_X and REG_Y storage; events latch regardless of FSM state.
    always_ff @(posedge np_clk) begin
        if (np_rst) begin
            x_q     <= '0;
            y_q     <= '0;
            evt_irq <= 1'b0;
        end else begin
            if (wr_x) begin
                x_q <= (x_q & ~wmask[15:0]) | (cpu.cpu_req_wdata[15:0] & wmask[15:0]);
            end
            y_q     <= y_next;
            evt_irq <= |y_next;
        end
    end

    blk_name_csr_evt_cnt u_evt_cnt (
        .np_clk (np_clk),
        .np_rst (np_rst),
        .inc    (|hw_evt),
        .clr    (rd_z),
        .count  (z_cnt)
    );

    // Response data for the request being accepted.
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (cpu.cpu_req_write) begin
            err_d = ~(sel_x | sel_y | sel_z);
        end else if (sel_x) begin
            rdata_d = {16'h0000, x_q};
        end else if (sel_y) begin
            rdata_d = 32'(y_q);
        end else if (sel_z) begin
            rdata_d = z_cnt;
        end else begin
            rdata_d = DECODE_ERR_RDATA;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge np_clk) begin
        if (np_rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu.cpu_req_ready  = req_ready;
    assign cpu.cpu_resp_valid = resp_valid;
    assign cpu.cpu_resp_rdata = rdata_q;
    assign cpu.cpu_resp_err   = err_q;
    assign reg_x_field_a      = x_q[REG_X_FIELD_A_MSB:REG_X_FIELD_A_LSB];
    assign reg_x_field_b      = x_q[REG_X_FIELD_B_MSB:REG_X_FIELD_B_LSB];
endmodule

// File: tb/tb_blk_name_csr_regs.sv
// -----------------------------------------------------------------------------
// tb_blk_name_csr_regs
//   Directed checks with hand-computed values, then randomized traffic.
//   A register-level model updates on every clock edge and a compare
//   process checks all DUT outputs against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_blk_name_csr_regs;
    logic       np_clk;
    logic       np_rst;
    logic [7:0] hw_evt;
    logic [7:0] reg_x_field_a;
    logic [7:0] reg_x_field_b;
    logic       evt_irq;

    int n_checks = 0;
    int n_errors = 0;

    blk_name_csr_if #(.NP_AWIDTH(16), .NP_DWIDTH(32)) bus ();

    blk_name_csr_regs #(.NP_AWIDTH(16), .NP_DWIDTH(32), .NUM_EVT(8)) dut (
        .np_clk        (np_clk),
        .np_rst        (np_rst),
        .cpu           (bus),
        .hw_evt        (hw_evt),
        .reg_x_field_a (reg_x_field_a),
        .reg_x_field_b (reg_x_field_b),
        .evt_irq       (evt_irq)
    );

    initial np_clk = 1'b0;
    always #5 np_clk = ~np_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0]       m_x;
    logic [7:0]        m_y;
    longint unsigned   m_z;
    bit                m_busy;
    logic [31:0]       m_rdata;
    logic              m_err;
    bit                model_on = 1'b0;

    always @(posedge np_clk) begin
        logic [7:0]  clr_y;
        bit          read_z;
        logic [31:0] mask;
        if (np_rst) begin
            m_x = '0; m_y = '0; m_z = 0; m_busy = 0; m_rdata = '0; m_err = 1'b0;
            model_on = 1'b1;
        end else begin
            clr_y  = '0;
            read_z = 0;
            if (m_busy) begin
                if (bus.cpu_resp_ready) m_busy = 0;
            end else if (bus.cpu_req_valid) begin
                m_busy  = 1;
                m_rdata = '0;
                m_err   = 1'b0;
                for (int b = 0; b < 4; b++)
                    mask[b*8 +: 8] = bus.cpu_req_be[b] ? 8'hFF : 8'h00;
                case (bus.cpu_req_addr)
                    16'h0020: begin
                        if (bus.cpu_req_write)
                            m_x = (m_x & ~mask[15:0]) | (bus.cpu_req_wdata[15:0] & mask[15:0]);
                        else
                            m_rdata = {16'h0, m_x};
                    end
                    16'h0021: begin
                        if (bus.cpu_req_write) clr_y = bus.cpu_req_wdata[7:0] & mask[7:0];
                        else                   m_rdata = {24'h0, m_y};
                    end
                    16'h0022: begin
                        if (!bus.cpu_req_write) begin
                            m_rdata = m_z[31:0];
                            read_z  = 1;
                        end
                    end
                    default: begin
                        m_err   = 1'b1;
                        m_rdata = bus.cpu_req_write ? 32'h0 : 32'hDEADBEEF;
                    end
                endcase
            end
            m_y = (m_y & ~clr_y) | hw_evt;
            if (read_z)                                     m_z = (hw_evt != 0) ? 1 : 0;
            else if (hw_evt != 0 && m_z < 64'hFFFF_FFFF)    m_z = m_z + 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge np_clk) begin
        if (model_on) begin
            check("cmp_req_ready",  32'(bus.cpu_req_ready),  32'(!m_busy));
            check("cmp_resp_valid", 32'(bus.cpu_resp_valid), 32'(m_busy));
            if (m_busy) begin
                check("cmp_resp_rdata", bus.cpu_resp_rdata, m_rdata);
                check("cmp_resp_err",   32'(bus.cpu_resp_err), 32'(m_err));
            end
            check("cmp_field_a", 32'(reg_x_field_a), 32'(m_x[7:0]));
            check("cmp_field_b", 32'(reg_x_field_b), 32'(m_x[15:8]));
            check("cmp_evt_irq", 32'(evt_irq), 32'(m_y != 0));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cpu_access(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [7:0] evt,
                              output logic [31:0] rdata, output logic err);
        int cyc = 0;
        bus.cpu_resp_ready = 1'b1;
        while (!bus.cpu_req_ready && cyc < 20) begin
            @(posedge np_clk); #1;
            cyc++;
        end
        check("req_ready_wait", 32'(bus.cpu_req_ready), 32'd1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_write = wr;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_wdata = wdata;
        bus.cpu_req_be    = be;
        hw_evt            = evt;
        @(posedge np_clk); #1;
        bus.cpu_req_valid = 1'b0;
        hw_evt            = '0;
        check("resp_latency", 32'(bus.cpu_resp_valid), 32'd1);
        rdata = bus.cpu_resp_rdata;
        err   = bus.cpu_resp_err;
        @(posedge np_clk); #1;
    endtask

    task automatic pulse(input logic [7:0] evt);
        hw_evt = evt;
        @(posedge np_clk); #1;
        hw_evt = '0;
    endtask

    logic [15:0] addr_tab [5] = '{16'h0020, 16'h0021, 16'h0022, 16'h0030, 16'h0000};

    initial begin
        logic [31:0] rd;
        logic        er;
        np_rst             = 1'b1;
        hw_evt             = '0;
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_req_write  = 1'b0;
        bus.cpu_req_addr   = '0;
        bus.cpu_req_wdata  = '0;
        bus.cpu_req_be     = '0;
        bus.cpu_resp_ready = 1'b1;
        repeat (3) @(posedge np_clk);
        #1 np_rst = 1'b0;

        // Reset state
        check("rst_req_ready",  32'(bus.cpu_req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
        check("rst_field_a",    32'(reg_x_field_a), 32'd0);
        check("rst_field_b",    32'(reg_x_field_b), 32'd0);
        check("rst_evt_irq",    32'(evt_irq), 32'd0);
        cpu_access(0, 16'h0022, '0, 4'h0, '0, rd, er);
        check("rst_reg_z", rd, 32'd0);

        // REG_X byte-enable write
        cpu_access(1, 16'h0020, 32'h0000_A55A, 4'b0001, '0, rd, er);
        check("wr_x_rdata", rd, 32'd0);
        check("wr_x_err", 32'(er), 32'd0);
        cpu_access(0, 16'h0020, '0, 4'h0, '0, rd, er);
        check("rd_x", rd, 32'h0000_005A);
        check("field_a", 32'(reg_x_field_a), 32'h5A);
        check("field_b", 32'(reg_x_field_b), 32'h00);

        // Unmapped address
        cpu_access(0, 16'h0030, '0, 4'h0, '0, rd, er);
        check("rd_unmapped_rdata", rd, 32'hDEADBEEF);
        check("rd_unmapped_err", 32'(er), 32'd1);
        cpu_access(1, 16'h0030, 32'hFFFF_FFFF, 4'hF, '0, rd, er);
        check("wr_unmapped_rdata", rd, 32'd0);
        check("wr_unmapped_err", 32'(er), 32'd1);
        cpu_access(0, 16'h0020, '0, 4'h0, '0, rd, er);
        check("rd_x_after_unmapped", rd, 32'h0000_005A);

        // REG_Y W1C
        pulse(8'h05);
        cpu_access(0, 16'h0021, '0, 4'h0, '0, rd, er);
        check("rd_y_05", rd, 32'h05);
        check("evt_irq_set", 32'(evt_irq), 32'd1);
        cpu_access(1, 16'h0021, 32'h01, 4'b0001, '0, rd, er);
        cpu_access(0, 16'h0021, '0, 4'h0, '0, rd, er);
        check("rd_y_04", rd, 32'h04);
        cpu_access(1, 16'h0021, 32'h04, 4'b0001, 8'h04, rd, er);
        cpu_access(0, 16'h0021, '0, 4'h0, '0, rd, er);
        check("rd_y_set_wins", rd, 32'h04);
        cpu_access(1, 16'h0021, 32'h04, 4'b0001, '0, rd, er);
        cpu_access(0, 16'h0021, '0, 4'h0, '0, rd, er);
        check("rd_y_cleared", rd, 32'h00);
        check("evt_irq_clear", 32'(evt_irq), 32'd0);

        // REG_Z: two event cycles so far (0x05 pulse, coincident 0x04)
        cpu_access(0, 16'h0022, '0, 4'h0, '0, rd, er);
        check("rd_z_prior", rd, 32'd2);
        for (int i = 0; i < 3; i++) begin
            pulse(8'h80);
            @(posedge np_clk); #1;
        end
        cpu_access(0, 16'h0022, '0, 4'h0, 8'h10, rd, er);
        check("rd_z_3", rd, 32'd3);
        cpu_access(0, 16'h0022, '0, 4'h0, '0, rd, er);
        check("rd_z_1", rd, 32'd1);
        cpu_access(1, 16'h0022, 32'h1234, 4'hF, '0, rd, er);
        check("wr_z_err", 32'(er), 32'd0);

        // Back-pressure then reset while response is pending
        bus.cpu_resp_ready = 1'b0;
        bus.cpu_req_valid  = 1'b1;
        bus.cpu_req_write  = 1'b0;
        bus.cpu_req_addr   = 16'h0020;
        @(posedge np_clk); #1;
        bus.cpu_req_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_resp_valid", 32'(bus.cpu_resp_valid), 32'd1);
            check("stall_rdata", bus.cpu_resp_rdata, 32'h0000_005A);
            check("stall_req_ready", 32'(bus.cpu_req_ready), 32'd0);
            @(posedge np_clk); #1;
        end
        np_rst = 1'b1;
        @(posedge np_clk); #1;
        np_rst = 1'b0;
        check("rst_drop_resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
        check("rst_drop_req_ready", 32'(bus.cpu_req_ready), 32'd1);
        check("rst_drop_field_a", 32'(reg_x_field_a), 32'd0);
        bus.cpu_resp_ready = 1'b1;

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            bus.cpu_req_valid  = ($urandom_range(0, 2) != 0);
            bus.cpu_req_write  = $urandom_range(0, 1) == 1;
            bus.cpu_req_addr   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : addr_tab[$urandom_range(0, 4)];
            bus.cpu_req_wdata  = $urandom;
            bus.cpu_req_be     = 4'($urandom_range(0, 15));
            bus.cpu_resp_ready = ($urandom_range(0, 3) != 0);
            hw_evt             = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            np_rst             = (i == 1500);
            @(posedge np_clk); #1;
        end
        np_rst            = 1'b0;
        bus.cpu_req_valid = 1'b0;
        hw_evt            = '0;
        repeat (3) @(posedge np_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
